memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles spent in a grant state without ACCESS before an error abort.
REQ-002 The block SHALL have port CLK  in  1  clock, rising-edge.
REQ-003 The block SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port iREN  in  1  instruction read request.
REQ-005 The block SHALL have port iaddr  in  32  instruction address.
REQ-006 The block SHALL have port iload  out  32  instruction read data.
REQ-007 The block SHALL have port iwait  out  1  instruction not complete.
REQ-008 The block SHALL have port dREN  in  1  data read request.
REQ-009 The block SHALL have port dWEN  in  1  data write request.
REQ-010 The block SHALL have port daddr  in  32  data address.
REQ-011 The block SHALL have port dstore  in  32  data write value.
REQ-012 The block SHALL have port dload  out  32  data read data.
REQ-013 The block SHALL have port dwait  out  1  data not complete.
REQ-014 The block SHALL have port ramREN  out  1  RAM read enable.
REQ-015 The block SHALL have port ramWEN  out  1  RAM write enable.
REQ-016 The block SHALL have port ramaddr  out  32  RAM address.
REQ-017 The block SHALL have port ramstore  out  32  RAM write data.
REQ-018 The block SHALL have port ramload  in  32  RAM read data.
REQ-019 The block SHALL have port ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 The block SHALL have port err  out  1  sticky error flag.

Function
REQ-021 The block SHALL implement the FSM states IDLE, DGRANT and IGRANT.
REQ-022 In IDLE, the grant SHALL be decided as follows:
- pending = dREN|dWEN; go to DGRANT.
- else iREN; go to IGRANT.
- Both pending and last completed grant was data: go to IGRANT (anti-starvation).
- Otherwise both pending: go to DGRANT.
REQ-023 On the grant edge, the block SHALL latch the address (daddr or iaddr), dstore and the op. dWEN SHALL win over dREN when both are high.
REQ-024 In a grant state, ramaddr, ramstore, ramREN and ramWEN SHALL be driven only from the latched registers. In IDLE, all four SHALL be 0.
REQ-025 In a grant state with ramstate==ACCESS, the granted requester's wait SHALL be 0 combinationally in that cycle, and the FSM SHALL go to IDLE on the next edge.
REQ-026 iload and dload SHALL both equal ramload combinationally; they are valid only when the corresponding wait is 0.
REQ-027 The non-granted wait, and both waits in IDLE, SHALL be 1 whenever the corresponding request is high. A wait SHALL be 0 whenever its request is low.
REQ-028 Minimum latency SHALL be 1 cycle in IDLE plus 1 grant cycle.
REQ-029 Back-to-back requests SHALL incur one IDLE cycle between transactions.
REQ-030 ramstate FREE or BUSY in a grant state SHALL hold the state; a 16-bit counter SHALL increment each such cycle.
REQ-031 When the counter reaches TIMEOUT-1, the block SHALL set err and go to IDLE without clearing the wait. The counter SHALL clear on every entry to IDLE.
REQ-032 ramstate==ERROR in a grant state SHALL set err and go to IDLE the next edge, with no wait deassertion.
REQ-033 If the granted requester drops its request mid-grant, the block SHALL go to IDLE the next edge, with no err and last-grant unchanged.
REQ-034 err SHALL be sticky until reset.

Reset
REQ-035 On nRST low, the block SHALL immediately set state IDLE, counter 0, last-grant instruction, err 0, and latched registers 0.
REQ-036 During reset, ramREN/ramWEN SHALL be 0 and ramaddr/ramstore SHALL be 0, including when reset is asserted mid-grant.

Verification
REQ-037 Scenario: iREN=1, iaddr=0x0000_0040, ramstate ACCESS immediately, ramload=0x2108_0001 -> ramREN=1, ramaddr=0x40 in cycle 1; iwait=0 and iload=0x2108_0001 in cycle 1; IDLE in cycle 2.
REQ-038 Scenario: dWEN=1 and iREN=1 simultaneously, daddr=0x80, dstore=0xDEAD_BEEF, last-grant instruction -> data served first with ramWEN=1 and ramstore=0xDEADBEEF; instruction granted after one IDLE cycle.
REQ-039 Scenario: dREN held high continuously with iREN high and ACCESS every grant -> grants alternate D, I, D, I; neither requester waits more than 4 cycles.
REQ-040 Scenario: TIMEOUT=4, iREN=1, ramstate BUSY forever -> err=1 after 4 grant cycles; FSM in IDLE; iwait stays 1; ram enables 0 in IDLE.
REQ-041 Scenario: ramstate=ERROR during DGRANT -> err=1 next edge; dwait remains 1; FSM in IDLE.
REQ-042 Scenario: nRST pulsed low mid-DGRANT -> ramWEN=0 asynchronously; err=0; after release, a pending dREN is granted normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single RAM port. Data wins ties
// unless the last completed grant was data, with a grant timeout and a sticky error.
module memory_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DGRANT = 2'd1;
    localparam logic [1:0] IGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] store;
        logic        ren;
        logic        wen;
    } txn_t;

    logic [1:0]  state_q, state_d;
    txn_t        txn_q, txn_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_data_q, last_data_d;  // last completed grant went to the data port
    logic        err_q, err_d;

    logic dreq;
    logic granted;
    logic grant_req;
    logic d_done, i_done;

    assign dreq      = dREN | dWEN;
    assign granted   = (state_q == DGRANT) || (state_q == IGRANT);
    assign grant_req = (state_q == DGRANT) ? dreq : iREN;
    assign d_done    = (state_q == DGRANT) && (ramstate == RAM_ACCESS);
    assign i_done    = (state_q == IGRANT) && (ramstate == RAM_ACCESS);

    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Data only yields when instruction is also waiting and data went last.
                if (dreq && !(iREN && last_data_q)) begin
                    state_d     = DGRANT;
                    txn_d.addr  = daddr;
                    txn_d.store = dstore;
                    txn_d.wen   = dWEN;
                    txn_d.ren   = dREN & ~dWEN;
                end else if (iREN) begin
                    state_d     = IGRANT;
                    txn_d.addr  = iaddr;
                    txn_d.store = '0;
                    txn_d.wen   = 1'b0;
                    txn_d.ren   = 1'b1;
                end
            end
            DGRANT, IGRANT: begin
                if (!grant_req) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_d     = IDLE;
                    last_data_d = (state_q == DGRANT);
                end else if (ramstate == RAM_ERROR) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (state_d == IDLE) begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            err_q       <= err_d;
        end
    end

    // RAM side sees only latched values, and nothing at all outside a grant.
    assign ramREN   = granted & txn_q.ren;
    assign ramWEN   = granted & txn_q.wen;
    assign ramaddr  = granted ? txn_q.addr  : '0;
    assign ramstore = granted ? txn_q.store : '0;

    assign iload = ramload;
    assign dload = ramload;
    assign iwait = iREN & ~i_done;
    assign dwait = dreq & ~d_done;
    assign err   = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a small RAM model plus a scoreboard of expected
// completions (port order and read data) checked whenever a wait drops.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [1:0]  ramstate;

    logic        force_en;
    logic [1:0]  force_st;
    logic [31:0] mem [0:255];

    typedef struct {
        bit          is_d;
        bit          is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    memory_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    // RAM model: answers ACCESS to any enable unless a status is forced.
    always_comb begin
        if (force_en) ramstate = force_st;
        else          ramstate = (ramREN || ramWEN) ? 2'd2 : 2'd0;
    end
    assign ramload = ramREN ? mem[ramaddr[9:2]] : 32'h0;
    always @(posedge CLK) if (ramWEN && ramstate == 2'd2) mem[ramaddr[9:2]] <= ramstore;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input bit d, input bit w, input logic [31:0] v);
        exp_t e;
        e.is_d = d; e.is_wr = w; e.data = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input bit is_d, input logic [31:0] load);
        exp_t e;
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(is_d ? "sb_order_d" : "sb_order_i", 32'(is_d), 32'(e.is_d));
            if (!e.is_wr) chk(is_d ? "sb_dload" : "sb_iload", load, e.data);
        end
    endtask

    always @(negedge CLK) begin
        #1;
        if (iREN && !iwait)            sb_pop(1'b0, iload);
        if ((dREN || dWEN) && !dwait)  sb_pop(1'b1, dload);
    end

    task automatic nxt();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int iw, dw, maxw;
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; force_en = 0; force_st = 0;
        #2;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_err", err, 0);
        chk("rst_iwait", iwait, 0);
        chk("rst_dwait", dwait, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // preload 0x40 through the arbiter
        dWEN = 1; daddr = 32'h40; dstore = 32'h2108_0001;
        push_exp(1, 1, 0);
        #1 chk("pre_idle_dwait", dwait, 1);
        nxt();
        #1 chk("pre_ramWEN", ramWEN, 1);
        chk("pre_ramstore", ramstore, 32'h2108_0001);
        chk("pre_dwait", dwait, 0);
        nxt();

        // single instruction fetch, ACCESS immediately
        dWEN = 0; iREN = 1; iaddr = 32'h40;
        push_exp(0, 0, 32'h2108_0001);
        #1 chk("s1_idle_ramREN", ramREN, 0);
        chk("s1_idle_iwait", iwait, 1);
        nxt();
        #1 chk("s1_ramREN", ramREN, 1);
        chk("s1_ramaddr", ramaddr, 32'h40);
        chk("s1_iwait", iwait, 0);
        nxt();

        // simultaneous data write and fetch, last grant instruction -> data first
        iaddr = 32'h80; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        push_exp(1, 1, 0);
        push_exp(0, 0, 32'hDEAD_BEEF);
        #1 chk("s1_c2_ramREN", ramREN, 0);
        chk("s2_idle_dwait", dwait, 1);
        chk("s2_idle_iwait", iwait, 1);
        nxt();
        #1 chk("s2_ramWEN", ramWEN, 1);
        chk("s2_ramREN", ramREN, 0);
        chk("s2_ramaddr", ramaddr, 32'h80);
        chk("s2_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("s2_iwait_held", iwait, 1);
        nxt();
        dWEN = 0;
        #1 chk("s2_gap_ramWEN", ramWEN, 0);
        chk("s2_gap_ramREN", ramREN, 0);
        chk("s2_gap_iwait", iwait, 1);
        nxt();
        #1 chk("s2_i_ramREN", ramREN, 1);
        chk("s2_i_ramaddr", ramaddr, 32'h80);
        chk("s2_i_iwait", iwait, 0);
        nxt();

        // both held high: D, I, D, I with one idle cycle between
        dREN = 1; daddr = 32'h40;
        for (int j = 0; j < 3; j++) begin
            push_exp(1, 0, 32'h2108_0001);
            push_exp(0, 0, 32'hDEAD_BEEF);
        end
        iw = 0; dw = 0; maxw = 0;
        for (int k = 0; k < 12; k++) begin
            #1 chk("alt_ramREN", ramREN, 32'(k % 2 == 1));
            if (k % 4 == 1) chk("alt_daddr", ramaddr, 32'h40);
            if (k % 4 == 3) chk("alt_iaddr", ramaddr, 32'h80);
            iw = iwait ? iw + 1 : 0;
            dw = dwait ? dw + 1 : 0;
            if (iw > maxw) maxw = iw;
            if (dw > maxw) maxw = dw;
            nxt();
        end
        chk("alt_maxwait_le4", 32'(maxw <= 4), 1);

        // ERROR during DGRANT
        iREN = 0; force_en = 1; force_st = 2'd3;
        #1 chk("err_idle_dwait", dwait, 1);
        nxt();
        #1 chk("err_grant_ramREN", ramREN, 1);
        chk("err_grant_dwait", dwait, 1);
        chk("err_grant_err", err, 0);
        nxt();
        force_en = 0;
        push_exp(1, 0, 32'h2108_0001);
        #1 chk("err_set", err, 1);
        chk("err_dwait_held", dwait, 1);
        chk("err_idle_ramREN", ramREN, 0);
        nxt();
        #1 chk("err_retry_dwait", dwait, 0);
        nxt();

        // reset pulsed mid-DGRANT
        dREN = 0; dWEN = 1; daddr = 32'h44; dstore = 32'h1234_5678;
        force_en = 1; force_st = 2'd1;
        #1 chk("rmid_err_before", err, 1);
        nxt();
        #1 chk("rmid_ramWEN_pre", ramWEN, 1);
        chk("rmid_ramaddr_pre", ramaddr, 32'h44);
        #2 nRST = 1'b0;
        #1 chk("rmid_ramWEN", ramWEN, 0);
        chk("rmid_ramaddr", ramaddr, 0);
        chk("rmid_ramstore", ramstore, 0);
        chk("rmid_err", err, 0);
        nxt();
        nRST = 1'b1; dWEN = 0; dREN = 1; daddr = 32'h40; force_en = 0;
        push_exp(1, 0, 32'h2108_0001);
        #1 chk("rpost_idle_dwait", dwait, 1);
        chk("rpost_idle_ramREN", ramREN, 0);
        nxt();
        #1 chk("rpost_ramREN", ramREN, 1);
        chk("rpost_ramaddr", ramaddr, 32'h40);
        chk("rpost_dwait", dwait, 0);
        nxt();

        // instruction drops mid-grant: no err, last grant stays data
        dREN = 0; iREN = 1; iaddr = 32'h80; force_en = 1; force_st = 2'd1;
        #1 chk("drop_idle_iwait", iwait, 1);
        nxt();
        #1 chk("drop_grant_ramREN", ramREN, 1);
        chk("drop_grant_iwait", iwait, 1);
        nxt();
        iREN = 0;
        #1 chk("drop_iwait_low", iwait, 0);
        nxt();
        force_en = 0; iREN = 1; dREN = 1;
        push_exp(0, 0, 32'hDEAD_BEEF);
        push_exp(1, 0, 32'h2108_0001);
        #1 chk("drop_idle_ramREN", ramREN, 0);
        chk("drop_no_err", err, 0);
        nxt();
        #1 chk("drop_next_is_i", ramaddr, 32'h80);
        chk("drop_next_dwait", dwait, 1);
        nxt();
        #1 chk("drop_gap_ramREN", ramREN, 0);
        nxt();
        #1 chk("drop_then_d", ramaddr, 32'h40);
        chk("drop_then_iwait", iwait, 1);
        nxt();

        // timeout with TIMEOUT=4 and RAM BUSY forever
        dREN = 0; iREN = 1; iaddr = 32'h40; force_en = 1; force_st = 2'd1;
        #1 chk("to_idle_iwait", iwait, 1);
        nxt();
        for (int g = 0; g < 4; g++) begin
            #1 chk("to_grant_ramREN", ramREN, 1);
            chk("to_grant_iwait", iwait, 1);
            chk("to_grant_err", err, 0);
            nxt();
        end
        #1 chk("to_err", err, 1);
        chk("to_iwait_held", iwait, 1);
        chk("to_idle_ramREN", ramREN, 0);
        chk("to_idle_ramWEN", ramWEN, 0);
        chk("to_idle_ramaddr", ramaddr, 0);
        nxt();
        iREN = 0;
        #1 chk("to_drop_iwait", iwait, 0);
        chk("to_err_sticky", err, 1);
        nxt();
        #1 chk("to_end_ramREN", ramREN, 0);
        chk("to_end_err", err, 1);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
